branch_predictor_param: RTL and testbench

- Parametrised successor to the fixed 2-bit/4-deep branch predictor, sitting between IF and the commit stage.
- Keeps a direct-mapped table of saturating counters with configurable size and width. Optional gshare indexing uses a committed global history register.
- Keeps an in-flight FIFO of predictions of configurable depth. At commit it resolves each branch and issues a single flush with the correct redirect address on mispredict.
- Adds branch and mispredict performance counters.

---
 rtl/branch_predictor_param.sv | 138 +++++++++++++
 tb/tb_branch_predictor_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_param.sv
// Branch predictor with a table of saturating counters (bimodal or gshare-indexed) and an
// in-flight FIFO of predictions that is resolved at commit, producing a single redirect flush.
module branch_predictor_param #(
   parameter int FIFO_DEPTH  = 4,
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_WIDTH   = 2,
   parameter int GHR_WIDTH   = 0,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  ask_predictor,
   input  logic [ADDR_WIDTH-1:0] now_ins_addr,
   input  logic [ADDR_WIDTH-1:0] jump_addr_from_if,
   input  logic [ADDR_WIDTH-1:0] next_addr_from_if,
   output logic                  jump,
   output logic                  predictor_sgn_rdy,
   output logic                  predictor_full,
   input  logic                  branch_commit,
   input  logic                  branch_jump,
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] addr_to_if,
   output logic [31:0]           branch_cnt,
   output logic [31:0]           mispredict_cnt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int GHR_W = (GHR_WIDTH > 0) ? GHR_WIDTH : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   function automatic logic [CNT_WIDTH-1:0] sat_update(input logic [CNT_WIDTH-1:0] c,
                                                       input logic taken);
      if (taken) return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
      else       return (c == '0)      ? c : c - CNT_WIDTH'(1);
   endfunction

   logic [PTR_W:0]          r_head, r_tail;
   logic [GHR_W-1:0]        r_ghr;
   logic [CNT_WIDTH-1:0]    r_bht [BHT_ENTRIES];
   logic [IDX_W-1:0]        r_fifo_idx   [FIFO_DEPTH];
   logic                    r_fifo_pred  [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   r_fifo_jaddr [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   r_fifo_naddr [FIFO_DEPTH];
   logic                    r_jump, r_sgn_rdy, r_flush;
   logic [ADDR_WIDTH-1:0]   r_addr_to_if;
   logic [31:0]             r_branch_cnt, r_mispredict_cnt;

   logic [PTR_W-1:0]        w_head_slot, w_tail_slot;
   logic                    w_empty, w_full;
   logic [IDX_W-1:0]        w_hist, w_idx, w_c_idx;
   logic                    w_pred, w_c_pred;
   logic                    w_commit, w_mispred, w_ask_ok;
   logic [ADDR_WIDTH-1:0]   w_redirect;
   logic                    w_unused_addr;

   assign w_head_slot = r_head[PTR_W-1:0];
   assign w_tail_slot = r_tail[PTR_W-1:0];
   assign w_empty     = (r_head == r_tail);
   assign w_full      = (r_head[PTR_W] != r_tail[PTR_W]) && (w_head_slot == w_tail_slot);

   // History is folded into the low index bits; bimodal builds see a constant zero.
   assign w_hist = (GHR_WIDTH > 0) ? IDX_W'(r_ghr) : '0;
   assign w_idx  = now_ins_addr[IDX_W+1:2] ^ w_hist;
   assign w_pred = r_bht[w_idx][CNT_WIDTH-1];

   assign w_c_idx    = r_fifo_idx[w_head_slot];
   assign w_c_pred   = r_fifo_pred[w_head_slot];
   assign w_commit   = rdy && branch_commit && !w_empty;
   assign w_mispred  = w_commit && (branch_jump != w_c_pred);
   assign w_ask_ok   = rdy && ask_predictor && !w_full && !w_mispred;
   assign w_redirect = branch_jump ? r_fifo_jaddr[w_head_slot] : r_fifo_naddr[w_head_slot];

   assign w_unused_addr = ^{now_ins_addr[ADDR_WIDTH-1:IDX_W+2], now_ins_addr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head           <= '0;
         r_tail           <= '0;
         r_ghr            <= '0;
         r_jump           <= 1'b0;
         r_sgn_rdy        <= 1'b0;
         r_flush          <= 1'b0;
         r_addr_to_if     <= '0;
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else if (rdy) begin
         r_sgn_rdy <= w_ask_ok;
         r_jump    <= w_ask_ok && w_pred;
         r_flush   <= w_mispred;
         if (w_commit) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            r_ghr        <= (GHR_WIDTH > 0) ? GHR_W'({r_ghr, branch_jump}) : '0;
         end
         if (w_mispred) begin
            r_addr_to_if     <= w_redirect;
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            r_head           <= '0;
            r_tail           <= '0;
         end else begin
            r_head <= r_head + (PTR_W+1)'(w_commit);
            r_tail <= r_tail + (PTR_W+1)'(w_ask_ok);
         end
      end else begin
         r_sgn_rdy <= 1'b0;
         r_flush   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CNT_INIT;
      end else if (w_commit) begin
         r_bht[w_c_idx] <= sat_update(r_bht[w_c_idx], branch_jump);
      end
   end

   // Slot payload carries no reset; occupancy is governed solely by the pointers.
   always_ff @(posedge clk) begin
      if (w_ask_ok) begin
         r_fifo_idx[w_tail_slot]   <= w_idx;
         r_fifo_pred[w_tail_slot]  <= w_pred;
         r_fifo_jaddr[w_tail_slot] <= jump_addr_from_if;
         r_fifo_naddr[w_tail_slot] <= next_addr_from_if;
      end
   end

   assign jump              = r_jump;
   assign predictor_sgn_rdy = r_sgn_rdy;
   assign predictor_full    = w_full;
   assign flush             = r_flush;
   assign addr_to_if        = r_addr_to_if;
   assign branch_cnt        = r_branch_cnt;
   assign mispredict_cnt    = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor_param.sv
// Bench for branch_predictor_param: a bimodal and a gshare instance share one stimulus stream
// and are checked every cycle against a queue-based behavioural model, plus literal expectations.
module tb_branch_predictor_param;

   localparam int D  = 4;
   localparam int E  = 16;
   localparam int CW = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b0;
   logic        ask_predictor = 1'b0;
   logic [31:0] now_ins_addr = '0;
   logic [31:0] jump_addr_from_if = '0;
   logic [31:0] next_addr_from_if = '0;
   logic        branch_commit = 1'b0;
   logic        branch_jump = 1'b0;

   logic        w_jump [2];
   logic        w_sgn [2];
   logic        w_full [2];
   logic        w_flush [2];
   logic [31:0] w_addr [2];
   logic [31:0] w_bc [2];
   logic [31:0] w_mc [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   branch_predictor_param #(.FIFO_DEPTH(D), .BHT_ENTRIES(E), .CNT_WIDTH(CW), .GHR_WIDTH(0),
                            .ADDR_WIDTH(32)) u_bim (
      .clk(clk), .rst(rst), .rdy(rdy), .ask_predictor(ask_predictor),
      .now_ins_addr(now_ins_addr), .jump_addr_from_if(jump_addr_from_if),
      .next_addr_from_if(next_addr_from_if), .jump(w_jump[0]), .predictor_sgn_rdy(w_sgn[0]),
      .predictor_full(w_full[0]), .branch_commit(branch_commit), .branch_jump(branch_jump),
      .flush(w_flush[0]), .addr_to_if(w_addr[0]), .branch_cnt(w_bc[0]),
      .mispredict_cnt(w_mc[0]));

   branch_predictor_param #(.FIFO_DEPTH(D), .BHT_ENTRIES(E), .CNT_WIDTH(CW), .GHR_WIDTH(2),
                            .ADDR_WIDTH(32)) u_gsh (
      .clk(clk), .rst(rst), .rdy(rdy), .ask_predictor(ask_predictor),
      .now_ins_addr(now_ins_addr), .jump_addr_from_if(jump_addr_from_if),
      .next_addr_from_if(next_addr_from_if), .jump(w_jump[1]), .predictor_sgn_rdy(w_sgn[1]),
      .predictor_full(w_full[1]), .branch_commit(branch_commit), .branch_jump(branch_jump),
      .flush(w_flush[1]), .addr_to_if(w_addr[1]), .branch_cnt(w_bc[1]),
      .mispredict_cnt(w_mc[1]));

   // ---------------- behavioural model ----------------
   typedef struct {
      int          idx;
      bit          pred;
      logic [31:0] ja;
      logic [31:0] na;
   } rec_t;

   int          ghrw [2] = '{0, 2};
   rec_t        mq [2][$];
   int          tbl [2][E];
   int          ghr [2];
   bit          e_sgn [2];
   bit          e_jump [2];
   bit          e_flush [2];
   logic [31:0] e_addr [2];
   logic [31:0] e_bc [2];
   logic [31:0] e_mc [2];

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < E; i++) tbl[k][i] = 2**(CW-1) - 1;
         ghr[k] = 0;
         mq[k].delete();
         e_sgn[k] = 0; e_jump[k] = 0; e_flush[k] = 0;
         e_addr[k] = '0; e_bc[k] = '0; e_mc[k] = '0;
      end
   endtask

   task automatic mstep(input int k);
      rec_t e, r;
      bit   com, mis, acc;
      com = branch_commit && (mq[k].size() > 0);
      mis = 0;
      if (com) begin
         e = mq[k][0];
         mis = (branch_jump != e.pred);
      end
      acc = ask_predictor && (mq[k].size() < D) && !mis;
      if (acc) begin
         r.idx  = (int'(now_ins_addr >> 2) % E) ^ ghr[k];
         r.pred = (tbl[k][r.idx] >= 2**(CW-1));
         r.ja   = jump_addr_from_if;
         r.na   = next_addr_from_if;
      end
      e_sgn[k]   = acc;
      e_jump[k]  = acc && r.pred;
      e_flush[k] = mis;
      if (com) begin
         if (branch_jump) tbl[k][e.idx] = (tbl[k][e.idx] < 2**CW - 1) ? tbl[k][e.idx] + 1 : tbl[k][e.idx];
         else             tbl[k][e.idx] = (tbl[k][e.idx] > 0) ? tbl[k][e.idx] - 1 : 0;
         ghr[k] = (ghrw[k] == 0) ? 0 : ((ghr[k] * 2) + int'(branch_jump)) % (2**ghrw[k]);
         e_bc[k] = e_bc[k] + 32'd1;
         if (mis) begin
            e_mc[k] = e_mc[k] + 32'd1;
            e_addr[k] = branch_jump ? e.ja : e.na;
            mq[k].delete();
         end else begin
            void'(mq[k].pop_front());
         end
      end
      if (acc) mq[k].push_back(r);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) mreset();
      else if (rdy) begin
         for (int k = 0; k < 2; k++) mstep(k);
      end else begin
         for (int k = 0; k < 2; k++) begin
            e_sgn[k] = 0;
            e_flush[k] = 0;
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk("sgn_rdy", k, 32'(w_sgn[k]), 32'(e_sgn[k]));
         if (e_sgn[k]) chk("jump", k, 32'(w_jump[k]), 32'(e_jump[k]));
         chk("flush", k, 32'(w_flush[k]), 32'(e_flush[k]));
         if (e_flush[k]) chk("addr_to_if", k, w_addr[k], e_addr[k]);
         chk("full", k, 32'(w_full[k]), 32'(mq[k].size() == D));
         chk("branch_cnt", k, w_bc[k], e_bc[k]);
         chk("mispredict_cnt", k, w_mc[k], e_mc[k]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic a, input logic [31:0] pc, input logic [31:0] ja,
                      input logic [31:0] na, input logic c, input logic bj, input logic r);
      @(negedge clk);
      rdy = r; ask_predictor = a; now_ins_addr = pc;
      jump_addr_from_if = ja; next_addr_from_if = na;
      branch_commit = c; branch_jump = bj;
   endtask

   task automatic ask(input logic [31:0] pc, input logic [31:0] ja);
      drv(1'b1, pc, ja, pc + 32'd4, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic com(input logic bj);
      drv(1'b0, '0, '0, '0, 1'b1, bj, 1'b1);
   endtask

   task automatic idle();
      drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_sgn", 0, 32'(w_sgn[0]), 32'd0);
      chk("rst_jump", 0, 32'(w_jump[0]), 32'd0);
      chk("rst_flush", 0, 32'(w_flush[0]), 32'd0);
      chk("rst_addr", 0, w_addr[0], 32'd0);
      chk("rst_full", 1, 32'(w_full[1]), 32'd0);
      rst = 1'b0;
      rdy = 1'b1;

      // First branch: weakly-not-taken prediction, taken outcome redirects to target.
      ask(32'h100, 32'h200);
      com(1'b1);
      chk("lit_first_sgn", 0, 32'(w_sgn[0]), 32'd1);
      chk("lit_first_jump", 0, 32'(w_jump[0]), 32'd0);
      idle();
      chk("lit_first_flush", 0, 32'(w_flush[0]), 32'd1);
      chk("lit_first_addr", 0, w_addr[0], 32'h200);
      chk("lit_first_bc", 0, w_bc[0], 32'd1);
      chk("lit_first_mc", 0, w_mc[0], 32'd1);

      ask(32'h100, 32'h200);
      com(1'b1);
      chk("lit_second_jump", 0, 32'(w_jump[0]), 32'd1);
      idle();
      chk("lit_second_flush", 0, 32'(w_flush[0]), 32'd0);
      ask(32'h100, 32'h200);
      com(1'b1);
      chk("lit_third_jump", 0, 32'(w_jump[0]), 32'd1);
      ask(32'h100, 32'h200);
      com(1'b0);
      idle();
      chk("lit_nt_flush", 0, 32'(w_flush[0]), 32'd1);
      chk("lit_nt_addr", 0, w_addr[0], 32'h104);
      chk("lit_nt_bc", 0, w_bc[0], 32'd4);
      chk("lit_nt_mc", 0, w_mc[0], 32'd2);

      // Fill, overflow, then wrap the pointers.
      for (int i = 0; i < 4; i++) ask(32'h10 + 32'(4*i), 32'h1000 + 32'(16*i));
      ask(32'h20, 32'h1040);
      chk("lit_full_set", 0, 32'(w_full[0]), 32'd1);
      idle();
      chk("lit_drop_sgn", 0, 32'(w_sgn[0]), 32'd0);
      chk("lit_drop_full", 0, 32'(w_full[0]), 32'd1);
      com(1'b0);
      drv(1'b1, 32'h20, 32'h1040, 32'h24, 1'b1, 1'b0, 1'b1);
      chk("lit_after_commit_full", 0, 32'(w_full[0]), 32'd0);
      ask(32'h24, 32'h1050);
      chk("lit_askcommit_sgn", 0, 32'(w_sgn[0]), 32'd1);
      chk("lit_askcommit_full", 0, 32'(w_full[0]), 32'd0);
      idle();
      chk("lit_refull", 0, 32'(w_full[0]), 32'd1);
      com(1'b0);
      com(1'b0);
      com(1'b0);
      chk("lit_drain_flush", 0, 32'(w_flush[0]), 32'd0);
      com(1'b1);
      idle();
      chk("lit_wrap_flush", 0, 32'(w_flush[0]), 32'd1);
      chk("lit_wrap_addr", 0, w_addr[0], 32'h1050);
      chk("lit_wrap_bc", 0, w_bc[0], 32'd10);
      chk("lit_wrap_mc", 0, w_mc[0], 32'd3);

      // Ask in the same cycle as a mispredicting commit is dropped.
      ask(32'h30, 32'h3000);
      drv(1'b1, 32'h34, 32'h3400, 32'h38, 1'b1, 1'b1, 1'b1);
      idle();
      chk("lit_same_flush", 0, 32'(w_flush[0]), 32'd1);
      chk("lit_same_addr", 0, w_addr[0], 32'h3000);
      chk("lit_same_sgn", 0, 32'(w_sgn[0]), 32'd0);
      chk("lit_same_full", 0, 32'(w_full[0]), 32'd0);
      chk("lit_same_mc", 0, w_mc[0], 32'd4);
      com(1'b1);
      idle();
      chk("lit_empty_commit_bc", 0, w_bc[0], 32'd11);
      chk("lit_empty_commit_flush", 0, 32'(w_flush[0]), 32'd0);

      // Stall: rdy low with ask and commit asserted.
      ask(32'h38, 32'h3800);
      drv(1'b1, 32'h38, 32'h3800, 32'h3C, 1'b1, 1'b1, 1'b0);
      chk("lit_stall_pre_sgn", 0, 32'(w_sgn[0]), 32'd1);
      drv(1'b1, 32'h38, 32'h3800, 32'h3C, 1'b1, 1'b1, 1'b0);
      chk("lit_stall_sgn", 0, 32'(w_sgn[0]), 32'd0);
      drv(1'b1, 32'h38, 32'h3800, 32'h3C, 1'b1, 1'b1, 1'b0);
      chk("lit_stall_bc", 0, w_bc[0], 32'd11);
      com(1'b0);
      chk("lit_stall_flush", 0, 32'(w_flush[0]), 32'd0);
      idle();
      chk("lit_resume_bc", 0, w_bc[0], 32'd12);
      chk("lit_resume_flush", 0, 32'(w_flush[0]), 32'd0);

      // Asynchronous reset between clock edges.
      ask(32'h100, 32'h200);
      @(posedge clk);
      #1;
      chk("lit_prerst_sgn", 0, 32'(w_sgn[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("lit_arst_sgn", 0, 32'(w_sgn[0]), 32'd0);
      chk("lit_arst_jump", 0, 32'(w_jump[0]), 32'd0);
      chk("lit_arst_bc", 0, w_bc[0], 32'd0);
      chk("lit_arst_mc", 0, w_mc[0], 32'd0);
      chk("lit_arst_addr", 0, w_addr[0], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ask_predictor = 1'b0;

      // History 11 vs 00 on the same PC select different counters in the gshare instance.
      ask(32'h100, 32'h200); com(1'b0);
      ask(32'h10, 32'h1000); com(1'b1);
      ask(32'h10, 32'h1000); com(1'b1);
      ask(32'h100, 32'h200); com(1'b1);
      ask(32'h100, 32'h200); com(1'b1);
      chk("lit_h11_gsh_jump", 1, 32'(w_jump[1]), 32'd1);
      chk("lit_h11_bim_jump", 0, 32'(w_jump[0]), 32'd0);
      ask(32'h10, 32'h1000); com(1'b0);
      ask(32'h10, 32'h1000); com(1'b0);
      ask(32'h100, 32'h200);
      idle();
      chk("lit_h00_gsh_sgn", 1, 32'(w_sgn[1]), 32'd1);
      chk("lit_h00_gsh_jump", 1, 32'(w_jump[1]), 32'd0);
      chk("lit_h00_bim_jump", 0, 32'(w_jump[0]), 32'd1);

      repeat (3) idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
